// File: rtl/stream_demux.sv
// stream_demux: routes a valid/ready byte stream to one of three one-entry
// channel buffers (alpha, beta, gamma), or discards it.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data/in_valid    upstream byte and its valid flag
//   in_ready            combinational accept for the current cycle
//   sel                 destination: 0 alpha, 1 beta, 2 gamma, 3 discard
//   cs                  chip select; 0 discards every accepted byte
//   <ch>_data/<ch>_valid/<ch>_ready   per-channel registered output stream
//   drop_cnt            saturating discard count (only with STREAM_DEMUX_DROP_CNT_EN)
//
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN
module stream_demux (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] sel,
  input  logic       cs,
  output logic [7:0] alpha_data,
  output logic       alpha_valid,
  input  logic       alpha_ready,
  output logic [7:0] beta_data,
  output logic       beta_valid,
  input  logic       beta_ready,
  output logic [7:0] gamma_data,
  output logic       gamma_valid,
  input  logic       gamma_ready
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] buf_data [NUM_CH];
  logic [NUM_CH-1:0] buf_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [3:0]        busy;
  logic [NUM_CH-1:0] load;
  logic              xfer;
  logic              discard;

  assign ch_ready = {gamma_ready, beta_ready, alpha_ready};

  // A channel blocks the input only when full and not draining this cycle;
  // slot 3 (discard) never blocks.
  always_comb begin
    busy = 4'b0000;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = buf_valid[i] & ~ch_ready[i];
    end
  end

  assign in_ready = ~cs | ~busy[sel];
  assign xfer     = in_valid & in_ready;
  assign discard  = xfer & (~cs | (sel == 2'd3));

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = xfer & cs & (sel == 2'(i));
    end
  end

  // Per-channel one-entry buffers; a load wins over a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          buf_data[i]  <= in_data;
          buf_valid[i] <= 1'b1;
        end else if (ch_ready[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign alpha_data  = buf_data[0];
  assign alpha_valid = buf_valid[0];
  assign beta_data   = buf_data[1];
  assign beta_valid  = buf_valid[1];
  assign gamma_data  = buf_data[2];
  assign gamma_valid = buf_valid[2];

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0] drop_q;

  // Saturating count of discarded transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (discard && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed scenarios plus randomized traffic for
// stream_demux, checked every cycle against an occupancy-based channel model.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       cs;
  logic [2:0] ready;
  logic [7:0] alpha_data, beta_data, gamma_data;
  logic       alpha_valid, beta_valid, gamma_valid;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  stream_demux dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .cs          (cs),
    .alpha_data  (alpha_data),
    .alpha_valid (alpha_valid),
    .alpha_ready (ready[0]),
    .beta_data   (beta_data),
    .beta_valid  (beta_valid),
    .beta_ready  (ready[1]),
    .gamma_data  (gamma_data),
    .gamma_valid (gamma_valid),
    .gamma_ready (ready[2])
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: each channel holds at most one byte.
  bit       m_full [4];
  bit [7:0] m_byte [4];
  int       m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] ch_out(input int i);
    case (i)
      0:       return {alpha_valid, alpha_data};
      1:       return {beta_valid, beta_data};
      default: return {gamma_valid, gamma_data};
    endcase
  endfunction

  // Checks in_ready for the current inputs, clocks once, advances the model,
  // and checks every channel output after the edge.
  task automatic step();
    bit exp_rdy;
    bit xfer;
    logic [8:0] o;
    #1;
    exp_rdy = !cs || sel == 2'd3 || !m_full[sel] || ready[sel];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    xfer = in_valid && exp_rdy;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_full[i] = 0;
      m_drop = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_full[i] && ready[i]) m_full[i] = 0;
        if (xfer && cs && sel == 2'(i)) begin
          m_full[i] = 1;
          m_byte[i] = in_data;
        end
      end
      if (xfer && (!cs || sel == 2'd3) && m_drop < 255) m_drop++;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      o = ch_out(i);
      chk($sformatf("valid%0d", i), 32'(o[8]), 32'(m_full[i]));
      if (m_full[i]) chk($sformatf("data%0d", i), 32'(o[7:0]), 32'(m_byte[i]));
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  initial begin
    rst = 1; in_data = 0; in_valid = 0; sel = 0; cs = 1; ready = 3'b111;
    m_drop = 0;
    for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_byte[i] = 0; end
    @(posedge clk); #1;
    step();
    chk("rst_state", 32'({alpha_valid, beta_valid, gamma_valid, alpha_data, beta_data, gamma_data}), 32'd0);
    rst = 0;

    // Routing
    in_valid = 1; sel = 0; in_data = 8'h11; step();
    chk("route_a", 32'({alpha_valid, beta_valid, gamma_valid, alpha_data}), 32'({3'b100, 8'h11}));
    sel = 1; in_data = 8'h22; step();
    chk("route_b", 32'({alpha_valid, beta_valid, gamma_valid, beta_data}), 32'({3'b010, 8'h22}));
    sel = 2; in_data = 8'h33; step();
    chk("route_g", 32'({alpha_valid, beta_valid, gamma_valid, gamma_data}), 32'({3'b001, 8'h33}));
    in_valid = 0; step();

    // Back-pressure on beta
    ready = 3'b101; in_valid = 1; sel = 1; in_data = 8'hA5; step();
    in_data = 8'h5A; #1;
    chk("bp_stall", 32'(in_ready), 32'd0);
    step();
    chk("bp_hold", 32'({beta_valid, beta_data}), 32'({1'b1, 8'hA5}));
    ready = 3'b111; step();
    chk("bp_next", 32'({beta_valid, beta_data}), 32'({1'b1, 8'h5A}));
    in_valid = 0; step();
    chk("bp_drain", 32'(beta_valid), 32'd0);

    // Full throughput on gamma
    in_valid = 1; sel = 2;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i); step();
      chk("thru", 32'({gamma_valid, gamma_data}), 32'({1'b1, 8'(i)}));
    end
    in_valid = 0; step();

    // Discard
    rst = 1; step(); rst = 0;
    in_valid = 1; cs = 0; sel = 0; in_data = 8'hFF; step();
    cs = 1; sel = 3; in_data = 8'hEE; step();
    chk("disc_none", 32'({alpha_valid, beta_valid, gamma_valid}), 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("disc_cnt2", 32'(drop_cnt), 32'd2);
`endif
    for (int i = 0; i < 300; i++) step();
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("disc_sat", 32'(drop_cnt), 32'd255);
`endif

    // Reset mid-stream
    ready = 3'b110; sel = 0; in_data = 8'h7E; step();
    chk("rst_pre", 32'({alpha_valid, alpha_data}), 32'({1'b1, 8'h7E}));
    rst = 1; in_data = 8'h42; step();
    chk("rst_mid", 32'({alpha_valid, beta_valid, gamma_valid, alpha_data, beta_data, gamma_data}), 32'd0);
    rst = 0; in_valid = 0; step();
    chk("rst_lost", 32'(alpha_valid), 32'd0);

    // cs drop does not flush
    ready = 3'b101; in_valid = 1; sel = 1; in_data = 8'h99; step();
    cs = 0; in_data = 8'h12; step();
    in_valid = 0; step();
    chk("cs_hold", 32'({beta_valid, beta_data}), 32'({1'b1, 8'h99}));
    ready = 3'b111; step();
    chk("cs_drain", 32'(beta_valid), 32'd0);
    cs = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      sel      = 2'($urandom);
      cs       = ($urandom_range(0, 7) != 0);
      ready    = 3'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset.
REQ-002 Input port: in_data  input  8  byte offered by the upstream source.
REQ-003 Input port: in_valid  input  1  in_data is valid this cycle.
REQ-004 Output port: in_ready  output  1  the block accepts in_data this cycle (combinational).
REQ-005 Input port: sel  input  2  destination select. 0 = alpha, 1 = beta, 2 = gamma, 3 = discard. Sampled together with in_data.
REQ-006 Input port: cs  input  1  chip select. 0 = every accepted byte is discarded.
REQ-007 For each ch in {alpha, beta, gamma}, the module SHALL have:
- ch_data  output  8  registered byte.
- ch_valid  output  1  ch_data holds an undelivered byte.
- ch_ready  input  1  downstream consumes the byte this cycle.
REQ-008 Output port: drop_cnt  output  8  saturating count of discarded bytes. Present only when STREAM_DEMUX_DROP_CNT_EN is defined.

Function
REQ-009 A transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1.
REQ-010 in_ready SHALL be 1 whenever any of the following holds:
- cs=0,
- sel=3,
- the selected channel buffer is empty,
- the selected channel's ch_valid=1 and ch_ready=1 in the same cycle.
Otherwise in_ready SHALL be 0.
REQ-011 Each channel SHALL hold a one-entry buffer. A transfer with cs=1 and sel=k SHALL load in_data into channel k and set its ch_valid=1 on the same edge. Latency is exactly 1 cycle from transfer to visible output.
REQ-012 A channel byte SHALL be delivered on an edge where ch_valid=1 and ch_ready=1. ch_valid SHALL then clear unless REQ-013 applies.
REQ-013 When a channel delivers and is loaded on the same edge:
- ch_data SHALL take the new byte,
- ch_valid SHALL remain 1,
- no bubble and no loss.
REQ-014 While ch_valid=1 and ch_ready=0, ch_data and ch_valid SHALL hold stable.
REQ-015 Unselected channels SHALL be unaffected by a transfer. Channels SHALL drain independently and concurrently.
REQ-016 A transfer with cs=0 or sel=3 SHALL be consumed and discarded. It SHALL change no channel output.
REQ-017 Deasserting cs SHALL NOT flush buffered bytes. Those bytes SHALL still drain normally.
REQ-018 With in_valid=0, no buffer SHALL be loaded, regardless of sel and cs.
REQ-019 Changes to sel or cs while in_valid=1 and in_ready=0 SHALL re-evaluate in_ready combinationally in that same cycle.

Reset
REQ-020 On a clk edge with rst=1, all of the following SHALL be 0:
- alpha_valid, beta_valid, gamma_valid,
- alpha_data, beta_data, gamma_data,
- drop_cnt, if present.
REQ-021 Reset SHALL override any simultaneous transfer or delivery. A byte presented on a reset edge SHALL be lost.
REQ-022 in_ready SHALL follow REQ-010 during reset, using the reset buffer state.

Configuration
REQ-023 When macro STREAM_DEMUX_DROP_CNT_EN is defined:
- drop_cnt SHALL exist.
- drop_cnt SHALL increment by 1 on every transfer discarded under REQ-016.
- drop_cnt SHALL saturate at 255.
REQ-024 When STREAM_DEMUX_DROP_CNT_EN is undefined:
- the drop_cnt port and its counter SHALL be absent,
- all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Routing: cs=1, all ch_ready=1. Send 0x11 with sel=0, 0x22 with sel=1, 0x33 with sel=2 on consecutive cycles -> each byte appears on its own channel exactly 1 cycle later. No other channel asserts valid.
- Back-pressure: beta_ready=0. Send 0xA5 then 0x5A with sel=1 -> beta_data holds 0xA5 and in_ready=0 on the second byte. Raise beta_ready -> 0xA5 is delivered, then 0x5A the next cycle.
- Full throughput: gamma_ready=1, sel=2. Stream 0x00..0x0F back-to-back -> in_ready stays 1 and gamma_valid stays 1 for 16 consecutive cycles with the data in order.
- Discard: cs=0, send 0xFF; then cs=1, sel=3, send 0xEE -> no channel valid. drop_cnt=2 when the macro is defined. 300 discards -> drop_cnt=255.
- Reset mid-stream: alpha_valid=1 holding 0x7E, assert rst while sending 0x42 with sel=0 -> after the edge all valids are 0, all data are 0, and 0x42 is lost.
- cs drop: fill beta with 0x99, ready=0. Set cs=0, then raise beta_ready -> 0x99 is still delivered.
